seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Downstream display stage for the up/down counter. It takes the counter's N-bit binary output and converts it to packed BCD with a sequential double-dabble engine. It then time-multiplexes the BCD digits onto a common seven-segment bus with one-hot digit enables. It runs continuously, re-sampling the input after each conversion, so the display follows the counter with bounded latency.

## Interface
- `N`, 12: width of the binary input.
- `DIGITS`, 4: number of display digits. Must satisfy 10^DIGITS > 2^N−1; elaboration fails otherwise.
- `REFRESH_DIV`, 50000: clk cycles each digit is held enabled. Must be ≥ 2.
- `ACTIVE_LOW`, 1: when 1, `seg` and `an` are inverted (common-anode board).
- `BLANK_LZ`, 1: when 1, leading-zero blanking is enabled.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `value`  in  N  binary number to display (the counter output).
- `bcd`  out  4*DIGITS  last completed conversion. Digit k is `bcd[4k+3:4k]`; digit 0 is the least significant.
- `bcd_valid`  out  1  single-cycle pulse when `bcd` updates.
- `seg`  out  7  segment drive, `{g,f,e,d,c,b,a}`.
- `an`  out  DIGITS  digit enables, one-hot; `an[0]` is the least significant digit.

## Operation
- Converter FSM has three states: IDLE → CONV → LATCH → IDLE. It never waits.
  - IDLE: snapshot `value` into the shift register and clear the BCD scratch register.
  - CONV: exactly N cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift `{bcd, bin}` left by 1.
  - LATCH: copy scratch to `bcd` and assert `bcd_valid` for this cycle only.
- `value` is sampled only in IDLE. Changes during CONV or LATCH are picked up at the next IDLE.
- Scratch BCD width is 4*DIGITS. Nibble compare/add is unsigned, 4-bit, with no carry between nibbles. Carries come only from the shift.
- Scan: `refresh` counts 0..REFRESH_DIV−1. On the terminal count it wraps to 0 and the digit index advances by 1, wrapping from DIGITS−1 to 0.
- Segment decode (active-high form): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Nibbles 10–15 decode to 00 (blank).
- Blanking with BLANK_LZ=1: digit k>0 is blanked (segment code 00) when nibbles k..DIGITS−1 of `bcd` are all zero. Digit 0 is never blanked. Interior zeros are always shown.
- `an` is active-high one-hot of the digit index before the ACTIVE_LOW inversion. `seg` and `an` are inverted together when ACTIVE_LOW=1.
- Reset, asynchronous and allowed at any point including mid-CONV:
  - FSM goes to IDLE; scratch, `bcd` and `refresh` go to 0; digit index goes to 0; `bcd_valid` goes to 0.
  - `an` and `seg` show digit 0 with pattern 3F. With ACTIVE_LOW=1 that is `an`=1110 and `seg`=40 for DIGITS=4.
  - On release, the first IDLE occurs on the first rising edge.

## Timing
- Conversion period is N+2 cycles, i.e. 14 for N=12.
- `value` sampled at edge t appears on `bcd` after edge t+N+1, with `bcd_valid` high during that cycle.
- `seg` and `an` are registered. They change one cycle after the digit index changes, and `seg` follows a `bcd` update with the same one-cycle delay.
- `an` and `seg` switch on the same edge, so no mixed-digit glitch is allowed.
- Each digit is enabled for exactly REFRESH_DIV cycles; the full scan takes DIGITS*REFRESH_DIV cycles.

## Structure
- Shared package `seg7_pkg` holds:
  - the segment pattern constants 0–9 and BLANK;
  - the converter state encoding (IDLE/CONV/LATCH, 2 bits);
  - a function that returns the segment code for a given nibble.
- One sub-module, `bin2bcd_seq` (parameters N and DIGITS), contains the FSM, the shift-add-3 datapath, `bcd` and `bcd_valid`.
- The top level contains the refresh counter, digit mux, blanking logic, decode and output registers.

## Test plan
All scenarios use N=12, DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1 unless noted.
- **Reset:** assert `reset` mid-CONV → `an`=1110, `seg`=40 and `bcd`=0000 immediately, with no `bcd_valid`. Release → first `bcd_valid` after 14 cycles.
- **Max value:** hold `value`=4095 → `bcd`=4095 (hex 0x4095) with a one-cycle `bcd_valid`. Pulses repeat every 14 cycles.
- **Mid-conversion change:** set `value`=100, then 200 three cycles after the IDLE sample → first result 0100, next result 0200.
- **Scan rotation:** constant input, observe `an` → sequence 1110, 1101, 1011, 0111, each held exactly 4 cycles, then wraps to 1110.
- **Blanking:** `value`=7 with BLANK_LZ=1 → digits 1–3 `seg`=7F, digit 0 `seg`=78. `value`=1000 → digit 3 `seg`=79, digits 0–2 `seg`=40.
- **Polarity:** ACTIVE_LOW=0 with `value`=8 → digit 0 `seg`=7F and `an`=0001 while digit 0 is selected.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment patterns,
// converter state encoding and the nibble-to-segment decoder.
package seg7_pkg;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] Seg0     = 7'h3F;
  localparam logic [6:0] Seg1     = 7'h06;
  localparam logic [6:0] Seg2     = 7'h5B;
  localparam logic [6:0] Seg3     = 7'h4F;
  localparam logic [6:0] Seg4     = 7'h66;
  localparam logic [6:0] Seg5     = 7'h6D;
  localparam logic [6:0] Seg6     = 7'h7D;
  localparam logic [6:0] Seg7     = 7'h07;
  localparam logic [6:0] Seg8     = 7'h7F;
  localparam logic [6:0] Seg9     = 7'h6F;
  localparam logic [6:0] SegBlank = 7'h00;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StConv  = 2'd1,
    StLatch = 2'd2
  } conv_state_e;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = Seg0;
      4'd1:    code = Seg1;
      4'd2:    code = Seg2;
      4'd3:    code = Seg3;
      4'd4:    code = Seg4;
      4'd5:    code = Seg5;
      4'd6:    code = Seg6;
      4'd7:    code = Seg7;
      4'd8:    code = Seg8;
      4'd9:    code = Seg9;
      default: code = SegBlank;
    endcase
    return code;
  endfunction

  // True when DIGITS decimal digits can hold the largest N-bit value.
  function automatic bit digits_fit(input int unsigned n, input int unsigned d);
    longint unsigned maxv;
    longint unsigned p;
    maxv = (64'd1 << n) - 64'd1;
    p    = 64'd1;
    for (int unsigned i = 0; i < d; i++) begin
      if (p <= maxv) p = p * 64'd10;
    end
    return p > maxv;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential double-dabble converter: samples value, runs N shift-add-3
// steps, then publishes the packed BCD result with a one-cycle valid pulse.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int unsigned N      = 12,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (!digits_fit(N, DIGITS)) begin : gen_digits_check
    $error("bin2bcd_seq: DIGITS too small to represent 2^N-1");
  end

  conv_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    bin_q, bin_d;
  logic [BcdW-1:0] scratch_q, scratch_d;
  logic [BcdW-1:0] bcd_q, bcd_d;
  logic            valid_q, valid_d;
  logic [BcdW-1:0] adj;

  // Per-nibble add-3 correction, no carry between nibbles
  always_comb begin
    adj = scratch_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        bin_d     = value;
        scratch_d = '0;
        cnt_d     = '0;
        state_d   = StConv;
      end
      StConv: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d              = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) state_d = StLatch;
      end
      StLatch: begin
        bcd_d   = scratch_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      valid_q   <= valid_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-seven-segment display driver: converts value to BCD and scans the
// digits onto a shared segment bus with one-hot digit enables.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N           = 12,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         value,
  output logic [4*DIGITS-1:0]  bcd,
  output logic                 bcd_valid,
  output logic [6:0]           seg,
  output logic [DIGITS-1:0]    an
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DigW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AnOne  = DIGITS'(1);
  localparam logic [6:0]        SegRst = ACTIVE_LOW ? ~Seg0 : Seg0;
  localparam logic [DIGITS-1:0] AnRst  = ACTIVE_LOW ? ~AnOne : AnOne;

  if (REFRESH_DIV < 2) begin : gen_refresh_check
    $error("seg7_scan_driver: REFRESH_DIV must be at least 2");
  end

  bin2bcd_seq #(
    .N      (N),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .bcd       (bcd),
    .bcd_valid (bcd_valid)
  );

  logic [RefW-1:0]   refresh_q, refresh_d;
  logic [DigW-1:0]   digit_q, digit_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS-1:0] lead_zero;
  logic              zero_run;
  logic [3:0]        nib;
  logic              blank;
  logic [6:0]        seg_raw;
  logic [DIGITS-1:0] an_raw;

  always_comb begin
    refresh_d = refresh_q + RefW'(1);
    digit_d   = digit_q;
    if (refresh_q == RefW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      digit_d   = (digit_q == DigW'(DIGITS - 1)) ? '0 : digit_q + DigW'(1);
    end
  end

  // Digit k is a leading zero when it and every more significant nibble are zero
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      zero_run     = zero_run & (bcd[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run & (k != 0);
    end
  end

  always_comb begin
    nib    = '0;
    blank  = 1'b0;
    an_raw = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (digit_q == DigW'(k)) begin
        nib       = bcd[4*k +: 4];
        blank     = lead_zero[k];
        an_raw[k] = 1'b1;
      end
    end
    seg_raw = (BLANK_LZ && blank) ? SegBlank : seg_decode(nib);
    seg_d   = ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d    = ACTIVE_LOW ? ~an_raw : an_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q <= '0;
      digit_q   <= '0;
      seg_q     <= SegRst;
      an_q      <= AnRst;
    end else begin
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
